npc_fetch_ctrl: RTL
===================

// Module: npc_fetch_ctrl
// PURPOSE
//  Next-PC generator for the fetch stage; producer side of the NPC->PC register path.
//  Each clock it decides the next fetch address (sequential increment, taken branch, jump, or hold on stall).
//  It drives NPC_reg_out into the PC register, plus fetch_valid and flush qualifiers for the IF/ID latch.
//  Contains a RUN/STALL/FLUSH state machine and a post-redirect flush counter.
// PARAMETERS
//  ADDR_W        10   PC/NPC width in bits
//  PC_INC        4    sequential increment added per fetch
//  RESET_PC      0    NPC value loaded by reset
//  FLUSH_CYCLES  1    bubble cycles after a redirect, >=1
// PORTS
//  clock          in   1        single clock; all state updates on posedge
//  reset          in   1        synchronous, active-high
//  stall          in   1        downstream cannot accept a fetch; hold NPC
//  branch_taken   in   1        taken branch resolved this cycle
//  branch_target  in   ADDR_W   branch destination
//  jump           in   1        jump resolved this cycle
//  jump_target    in   ADDR_W   jump destination
//  NPC_reg_out    out  ADDR_W   registered next PC, feeds PC register
//  fetch_valid    out  1        registered; current fetch is architecturally valid
//  flush          out  1        registered; kill IF/ID contents this cycle
// BEHAVIOUR
//  - One clock domain; reset is synchronous and active-high, clock port "clock", reset port "reset".
//  - All outputs registered. Reset: NPC_reg_out=RESET_PC, fetch_valid=0, flush=0, state=RUN, flush counter=0.
//  - Priority each edge: reset > jump > branch_taken > stall > increment.
//  - Redirect (jump or branch_taken): NPC_reg_out<=target, state<=FLUSH, counter<=FLUSH_CYCLES-1,
//    flush<=1, fetch_valid<=0. Redirect overrides stall and is accepted in any state.
//  - RUN, no redirect: stall=1 -> hold NPC, state<=STALL, fetch_valid<=0; else NPC<=NPC+PC_INC, fetch_valid<=1.
//  - STALL: hold NPC, fetch_valid=0 while stall=1; on stall=0, NPC<=NPC+PC_INC, state<=RUN, fetch_valid<=1.
//  - FLUSH: flush=1, fetch_valid=0 for exactly FLUSH_CYCLES cycles after the redirect edge; NPC increments
//    each FLUSH cycle unless stall=1 (then held). Counter decrements every cycle regardless of stall.
//    At counter 0: exit to STALL if stall=1, else RUN (fetch_valid<=1, flush<=0).
//  - Redirect during FLUSH restarts counter from FLUSH_CYCLES-1 with new target.
//  - Arithmetic: NPC+PC_INC truncated to ADDR_W bits (wraps modulo 2^ADDR_W); targets used unmodified.
//  - Latency: redirect input to NPC_reg_out change = 1 edge; PC register sees it 1 further edge later.
//  - Reset mid-FLUSH or mid-STALL: all state discarded, reset values on next edge.
//  - Unused state encodings fall back to RUN with NPC held.
// CONFIGURATION
//  NPC_REDIRECT_COUNT_EN defined: adds output redirect_count [15:0]; reset to 0, +1 on every accepted
//   redirect edge, saturates at 16'hFFFF.
//  Not defined: port absent, no counter logic; all other behaviour identical.
// TESTING
//  1. reset high 3 edges, release, no other inputs -> NPC 0x000,0x004,0x008,0x00C; fetch_valid 0 in reset, 1 after.
//  2. at NPC=0x008 pulse branch_taken, target 0x100 -> next edge NPC=0x100, flush=1, fetch_valid=0; next edge 0x104, valid=1.
//  3. jump=1 (0x080) and branch_taken=1 (0x100) same cycle -> NPC=0x080, flush=1.
//  4. stall high 2 cycles at NPC=0x010 -> NPC held 0x010, fetch_valid=0 both; stall low -> 0x014, valid=1.
//  5. NPC=0x3FC, no stall -> next NPC=0x000 (wrap), fetch_valid=1.
//  6. reset asserted during FLUSH (FLUSH_CYCLES=3) -> next edge NPC=RESET_PC, flush=0, fetch_valid=0;
//     with NPC_REDIRECT_COUNT_EN, redirect_count=0.

Source files
------------

// File: rtl/npc_fetch_ctrl.sv
// npc_fetch_ctrl: next-PC generator for the fetch stage.
//
// Each clock it picks the next fetch address. The choices are a sequential
// increment, a taken-branch target, a jump target, or holding the address on
// stall. It drives the PC register and the IF/ID fetch_valid/flush
// qualifiers. All outputs are registered.
//
// State table:
//   state    | meaning
//   ST_RUN   | normal sequential fetch, fetch_valid asserted
//   ST_STALL | downstream busy, NPC held, fetch_valid low
//   ST_FLUSH | post-redirect bubbles, flush high for FLUSH_CYCLES cycles
//
// Ports:
//   clock          in   single clock, all updates on posedge
//   reset          in   synchronous, active-high
//   stall          in   hold NPC, downstream cannot accept a fetch
//   branch_taken   in   taken branch resolved this cycle
//   branch_target  in   branch destination
//   jump           in   jump resolved this cycle (wins over branch)
//   jump_target    in   jump destination
//   NPC_reg_out    out  registered next PC
//   fetch_valid    out  registered, current fetch is architecturally valid
//   flush          out  registered, kill IF/ID contents this cycle
//   redirect_count out  saturating count of accepted redirects
//                       (present only with NPC_REDIRECT_COUNT_EN)
//
// Optional feature macro: NPC_REDIRECT_COUNT_EN
module npc_fetch_ctrl #(
    parameter int ADDR_W       = 10,
    parameter int PC_INC       = 4,
    parameter int RESET_PC     = 0,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] NPC_reg_out,
    output logic              fetch_valid,
`ifdef NPC_REDIRECT_COUNT_EN
    output logic              flush,
    output logic [15:0]       redirect_count
`else
    output logic              flush
`endif
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] npc_q, npc_d, npc_inc;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              flush_q, flush_d;
    logic              redirect;
    logic [ADDR_W-1:0] target;

    // Wraps modulo 2^ADDR_W by truncation.
    assign npc_inc  = npc_q + ADDR_W'(PC_INC);
    assign redirect = jump | branch_taken;
    assign target   = jump ? jump_target : branch_target;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            npc_q   <= ADDR_W'(RESET_PC);
            cnt_q   <= '0;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            npc_q   <= npc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        npc_d   = npc_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        flush_d = 1'b0;
        if (redirect) begin
            // Redirect beats stall and is taken from any state.
            npc_d   = target;
            state_d = ST_FLUSH;
            cnt_d   = CW'(FLUSH_CYCLES - 1);
            flush_d = 1'b1;
        end else begin
            case (state_q)
                ST_RUN, ST_STALL: begin
                    if (stall) begin
                        state_d = ST_STALL;
                    end else begin
                        npc_d   = npc_inc;
                        state_d = ST_RUN;
                        valid_d = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // Address keeps advancing during bubbles unless stalled;
                    // the bubble counter runs regardless of stall.
                    if (!stall) npc_d = npc_inc;
                    if (cnt_q == '0) begin
                        state_d = stall ? ST_STALL : ST_RUN;
                        valid_d = !stall;
                    end else begin
                        cnt_d   = cnt_q - CW'(1);
                        flush_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    assign NPC_reg_out = npc_q;
    assign fetch_valid = valid_q;
    assign flush       = flush_q;

`ifdef NPC_REDIRECT_COUNT_EN
    logic [15:0] rc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rc_q <= '0;
        end else if (redirect && (rc_q != 16'hFFFF)) begin
            rc_q <= rc_q + 16'd1;
        end
    end

    assign redirect_count = rc_q;
`endif

endmodule
